aes256_device: RTL and testbench

AES256_DEVICE -- requirements
Module: aes256_device

---
 rtl/aes256_device.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_aes256_device.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aes256_device.sv
// aes256_device: iterative FIPS-197 AES-256 encrypt/decrypt engine.
// One round per clock, with a 15-entry round-key store that is filled
// on-chip, one key per cycle, after both key halves have arrived.
//
// Ports
//   clk          : rising-edge clock
//   resetn       : asynchronous active-low reset
//   inp_device   : 128-bit key half or data block, byte i = bits [8i+7:8i]
//   ctrl_dataIn  : beat valid; inp_device and mod_en are sampled only when high
//   mod_en       : 2'b10 key half, 2'b00 encrypt, 2'b01 decrypt, 2'b11 ignored
//   outp_device  : result block (same byte mapping), held until the next result
//   ctrl_dataOut : one-cycle pulse when outp_device carries a new result
module aes256_device (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] inp_device,
    input  logic         ctrl_dataIn,
    input  logic [1:0]   mod_en,
    output logic [127:0] outp_device,
    output logic         ctrl_dataOut
);

    typedef enum logic [2:0] {IDLE, KEYEXP, READY, ENC, DEC} fsm_t;

    fsm_t          state, next_state;
    logic [127:0]  round_keys [0:14];
    logic          half_ptr;
    logic [3:0]    key_idx;
    logic          pending;
    logic [127:0]  pend_blk;
    logic          pend_mode;
    logic [127:0]  aes_state;
    logic [3:0]    round_cnt;

    logic          key_beat, block_beat;
    logic          load_lo, load_hi, exp_step, latch_pend, start_blk, do_round;
    logic [127:0]  start_data, start_key;
    logic          start_dec;
    logic [127:0]  new_rk;
    logic [31:0]   key_word;
    logic [7:0]    rcon;
    logic [127:0]  round_key, enc_sr, enc_out, dec_ark, dec_out, round_out;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = x;
        for (int i = 0; i < 7; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    // S-box computed as inverse followed by the affine transform, avoiding a table
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] v;
        v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return r;
    endfunction

    // State byte (row r, column c) lives at index r + 4c
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c + row) % 4)) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c + 4 - row) % 4)) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c +: 8]      = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            r[32*c + 8 +: 8]  = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            r[32*c + 24 +: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c +: 8]      = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[32*c + 8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    assign key_beat   = ctrl_dataIn && (mod_en == 2'b10);
    assign block_beat = ctrl_dataIn && !mod_en[1];

    // Round key n (n >= 2) from keys n-2 and n-1; even n takes RotWord+Rcon,
    // odd n takes a plain SubWord, matching the Nk=8 schedule.
    always_comb begin
        key_word = round_keys[key_idx - 4'd1][127:96];
        rcon     = 8'h01 << (key_idx[3:1] - 3'd1);
        if (!key_idx[0])
            key_word = sub_word({key_word[7:0], key_word[31:8]}) ^ {24'h0, rcon};
        else
            key_word = sub_word(key_word);
        new_rk[31:0]   = round_keys[key_idx - 4'd2][31:0]   ^ key_word;
        new_rk[63:32]  = round_keys[key_idx - 4'd2][63:32]  ^ new_rk[31:0];
        new_rk[95:64]  = round_keys[key_idx - 4'd2][95:64]  ^ new_rk[63:32];
        new_rk[127:96] = round_keys[key_idx - 4'd2][127:96] ^ new_rk[95:64];
    end

    // One cipher or inverse-cipher round; the last round skips (Inv)MixColumns
    always_comb begin
        round_key = round_keys[(state == DEC) ? (4'd14 - round_cnt) : round_cnt];
        enc_sr    = shift_rows(sub_bytes(aes_state));
        enc_out   = ((round_cnt == 4'd14) ? enc_sr : mix_columns(enc_sr)) ^ round_key;
        dec_ark   = inv_sub_bytes(inv_shift_rows(aes_state)) ^ round_key;
        dec_out   = (round_cnt == 4'd14) ? dec_ark : inv_mix_columns(dec_ark);
        round_out = (state == DEC) ? dec_out : enc_out;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (key_beat && half_ptr) next_state = KEYEXP;
            KEYEXP: if (key_idx == 4'd14) begin
                        if (block_beat)   next_state = mod_en[0] ? DEC : ENC;
                        else if (pending) next_state = pend_mode ? DEC : ENC;
                        else              next_state = READY;
                    end
            READY:  if (key_beat)         next_state = IDLE;
                    else if (block_beat)  next_state = mod_en[0] ? DEC : ENC;
            ENC,
            DEC:    if (round_cnt == 4'd14) next_state = READY;
            default: next_state = IDLE;
        endcase
    end

    // A block beat arriving on the last KEYEXP cycle supersedes the pending one
    always_comb begin
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        exp_step   = 1'b0;
        latch_pend = 1'b0;
        start_blk  = 1'b0;
        do_round   = 1'b0;
        start_data = inp_device;
        start_dec  = mod_en[0];
        case (state)
            IDLE: begin
                load_lo = key_beat && !half_ptr;
                load_hi = key_beat && half_ptr;
            end
            KEYEXP: begin
                exp_step   = 1'b1;
                latch_pend = block_beat;
                start_blk  = (key_idx == 4'd14) && (block_beat || pending);
                if (!block_beat) begin
                    start_data = pend_blk;
                    start_dec  = pend_mode;
                end
            end
            READY: begin
                load_lo   = key_beat;
                start_blk = block_beat;
            end
            ENC, DEC: do_round = 1'b1;
            default: ;
        endcase
    end

    // rk14 is still being written when a pending decrypt starts out of KEYEXP
    assign start_key = !start_dec ? round_keys[0]
                     : ((state == KEYEXP) ? new_rk : round_keys[14]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_ptr     <= 1'b0;
            key_idx      <= 4'd0;
            pending      <= 1'b0;
            pend_blk     <= 128'h0;
            pend_mode    <= 1'b0;
            aes_state    <= 128'h0;
            round_cnt    <= 4'd0;
            outp_device  <= 128'h0;
            ctrl_dataOut <= 1'b0;
            for (int i = 0; i < 15; i++) round_keys[i] <= 128'h0;
        end else begin
            ctrl_dataOut <= 1'b0;
            if (load_lo) begin
                round_keys[0] <= inp_device;
                half_ptr      <= 1'b1;
            end
            if (load_hi) begin
                round_keys[1] <= inp_device;
                half_ptr      <= 1'b0;
                key_idx       <= 4'd2;
            end
            if (exp_step) begin
                round_keys[key_idx] <= new_rk;
                key_idx             <= key_idx + 4'd1;
            end
            if (latch_pend) begin
                pend_blk  <= inp_device;
                pend_mode <= mod_en[0];
                pending   <= 1'b1;
            end
            if (start_blk) begin
                aes_state <= start_data ^ start_key;
                round_cnt <= 4'd1;
                pending   <= 1'b0;
            end
            if (do_round) begin
                aes_state <= round_out;
                round_cnt <= round_cnt + 4'd1;
                if (round_cnt == 4'd14) begin
                    outp_device  <= round_out;
                    ctrl_dataOut <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes256_device.sv
// tb_aes256_device: directed-vector bench for aes256_device. Stimulus pushes
// the expected result and its expected arrival cycle into a scoreboard queue;
// a monitor pops and compares whenever ctrl_dataOut pulses.
module tb_aes256_device;

    localparam logic [127:0] K_LO = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] K_HI = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] PT   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT   = 128'h8960494b9049fceabf456751cab7a28e;
    localparam logic [127:0] X24  = 128'h7a584d99febc93ead6b3563cc4ad3a63;

    typedef struct {
        logic [127:0] data;
        logic         check;
        int           cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] inp_device;
    logic         ctrl_dataIn;
    logic [1:0]   mod_en;
    logic [127:0] outp_device;
    logic         ctrl_dataOut;

    exp_t         sb_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cycle_cnt = 0;
    int           pulse_count = 0;
    logic         prev_pulse = 1'b0;
    logic [127:0] captured = 128'h0;

    aes256_device dut (
        .clk          (clk),
        .resetn       (resetn),
        .inp_device   (inp_device),
        .ctrl_dataIn  (ctrl_dataIn),
        .mod_en       (mod_en),
        .outp_device  (outp_device),
        .ctrl_dataOut (ctrl_dataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one beat on the falling edge; it is taken on the next rising edge
    task automatic applyStimulus(input logic [127:0] data, input logic [1:0] mode,
                                 output int accept);
        @(negedge clk);
        inp_device  = data;
        mod_en      = mode;
        ctrl_dataIn = 1'b1;
        accept      = cycle_cnt + 1;
        @(posedge clk);
        #1 ctrl_dataIn = 1'b0;
    endtask

    task automatic expectResult(input logic [127:0] data, input logic check, input int cycle);
        exp_t e;
        e.data  = data;
        e.check = check;
        e.cycle = cycle;
        sb_q.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic loadKey(input logic [127:0] lo, input logic [127:0] hi, output int accept_hi);
        int a;
        applyStimulus(lo, 2'b10, a);
        applyStimulus(hi, 2'b10, accept_hi);
    endtask

    // Monitor: pops one expectation per pulse, checks cycle and data
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (prev_pulse) checkOutput("pulse_width", {127'h0, ctrl_dataOut}, 128'h0);
            if (ctrl_dataOut === 1'b1) begin
                pulse_count++;
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_pulse: got outp %h with no result expected", outp_device);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("latency_cycle", 128'(cycle_cnt), 128'(e.cycle));
                    if (e.check) checkOutput("result", outp_device, e.data);
                    else         captured = outp_device;
                end
            end
            prev_pulse = ctrl_dataOut;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        int acc;
        int acc_hi;
        int pulses_before;

        resetn      = 1'b1;
        ctrl_dataIn = 1'b0;
        mod_en      = 2'b00;
        inp_device  = 128'h0;
        #2 resetn = 1'b0;
        waitCycles(2);
        checkOutput("reset_outp", outp_device, 128'h0);
        checkOutput("reset_pulse", {127'h0, ctrl_dataOut}, 128'h0);
        resetn = 1'b1;

        $display("[TB] block beats and mode 11 before a key is loaded");
        applyStimulus(PT, 2'b00, acc);
        applyStimulus(K_LO, 2'b10, acc);
        applyStimulus(PT, 2'b00, acc);
        applyStimulus(CT, 2'b01, acc);
        applyStimulus(PT, 2'b11, acc);
        applyStimulus(K_HI, 2'b10, acc);
        waitCycles(20);
        checkOutput("no_pulse_idle", 128'(pulse_count), 128'h0);
        checkOutput("outp_idle", outp_device, 128'h0);
        applyStimulus(PT, 2'b11, acc);
        waitCycles(20);
        checkOutput("no_pulse_mode11", 128'(pulse_count), 128'h0);
        checkOutput("outp_mode11", outp_device, 128'h0);

        $display("[TB] encrypt, decrypt, re-encrypt with the same key");
        applyStimulus(PT, 2'b00, acc);
        expectResult(CT, 1'b1, acc + 14);
        waitCycles(20);
        applyStimulus(CT, 2'b01, acc);
        expectResult(PT, 1'b1, acc + 14);
        waitCycles(20);
        applyStimulus(PT, 2'b00, acc);
        expectResult(CT, 1'b1, acc + 14);
        waitCycles(20);

        $display("[TB] beats during encryption are ignored");
        pulses_before = pulse_count;
        applyStimulus(PT, 2'b00, acc);
        expectResult(CT, 1'b1, acc + 14);
        waitCycles(4);
        applyStimulus(CT, 2'b01, acc);
        applyStimulus(K_LO, 2'b10, acc);
        waitCycles(25);
        checkOutput("one_pulse_busy", 128'(pulse_count - pulses_before), 128'h1);
        checkOutput("outp_held", outp_device, CT);

        $display("[TB] new key from READY, decrypt queued during key expansion");
        pulses_before = pulse_count;
        loadKey(K_LO, K_LO, acc_hi);
        applyStimulus(X24, 2'b01, acc);
        expectResult(128'h0, 1'b0, acc_hi + 27);
        waitCycles(35);
        checkOutput("one_pulse_queued", 128'(pulse_count - pulses_before), 128'h1);
        applyStimulus(captured, 2'b00, acc);
        expectResult(X24, 1'b1, acc + 14);
        waitCycles(20);

        $display("[TB] reset in the middle of an encryption");
        loadKey(K_LO, K_HI, acc_hi);
        waitCycles(16);
        applyStimulus(PT, 2'b00, acc);
        waitCycles(5);
        #2 resetn = 1'b0;
        #1;
        checkOutput("abort_outp", outp_device, 128'h0);
        checkOutput("abort_pulse", {127'h0, ctrl_dataOut}, 128'h0);
        pulses_before = pulse_count;
        waitCycles(3);
        resetn = 1'b1;
        waitCycles(20);
        checkOutput("no_pulse_after_abort", 128'(pulse_count - pulses_before), 128'h0);
        loadKey(K_LO, K_HI, acc_hi);
        waitCycles(16);
        applyStimulus(PT, 2'b00, acc);
        expectResult(CT, 1'b1, acc + 14);
        waitCycles(20);

        checkOutput("results_outstanding", 128'(sb_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
